// File: rtl/iter_normalizer.sv
// iter_normalizer: multi-cycle post-add normalizer for the FP adder.
// Ports: in_valid/in_ready take rawsum, stickyin, inexp and signin;
// out_valid/out_ready hand normsum, round, sticky, overexp, finalsign
// and the zero/denorm/overflow flags to the rounder.
module iter_normalizer #(
    parameter int WSIG = 23,
    parameter int WEXP = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WSIG+2:0] rawsum,
    input  logic            stickyin,
    input  logic [WEXP-1:0] inexp,
    input  logic            signin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WSIG-1:0] normsum,
    output logic            round,
    output logic            sticky,
    output logic [WEXP-1:0] overexp,
    output logic            finalsign,
    output logic            zero,
    output logic            denorm,
    output logic            overflow
);

    localparam int WW = WSIG + 3;
    localparam int WE = WEXP + 1;

    localparam logic [WE-1:0]   EONE = WE'(1);
    localparam logic [WE-1:0]   EOVF = WE'((1 << WEXP) - 2);
    localparam logic [WEXP-1:0] XONE = WEXP'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_n;

    // working significand/exponent; e is one bit wider than the output
    logic [WW-1:0]   w, w_n;
    logic [WE-1:0]   e, e_n;
    logic            stk, stk_n;

    logic [WSIG-1:0] normsum_n;
    logic            round_n;
    logic            sticky_n;
    logic [WEXP-1:0] overexp_n;
    logic            finalsign_n;
    logic            zero_n;
    logic            denorm_n;
    logic            overflow_n;

    // one-hot terminal conditions, ordered by priority
    logic c_carry, c_zero, c_norm, c_min;

    assign c_carry = w[WW-1];
    assign c_zero  = ~c_carry & (w == '0) & ~stk;
    assign c_norm  = ~c_carry & ~c_zero & w[WW-2];
    assign c_min   = ~c_carry & ~c_zero & ~w[WW-2] & (e == EONE);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_n     = state;
        w_n         = w;
        e_n         = e;
        stk_n       = stk;
        normsum_n   = normsum;
        round_n     = round;
        sticky_n    = sticky;
        overexp_n   = overexp;
        finalsign_n = finalsign;
        zero_n      = zero;
        denorm_n    = denorm;
        overflow_n  = overflow;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    w_n         = rawsum;
                    stk_n       = stickyin;
                    finalsign_n = signin;
                    // a zero exponent field still carries weight 1
                    e_n         = (inexp == '0) ? EONE : {1'b0, inexp};
                    zero_n      = 1'b0;
                    denorm_n    = 1'b0;
                    overflow_n  = 1'b0;
                    state_n     = SHIFT;
                end
            end

            SHIFT: begin
                unique case (1'b1)
                    c_carry: begin
                        normsum_n  = w[WW-2:2];
                        round_n    = w[1];
                        sticky_n   = w[0] | stk;
                        overexp_n  = e[WEXP-1:0];
                        overflow_n = (e == EOVF);
                        state_n    = DONE;
                    end
                    c_zero: begin
                        zero_n    = 1'b1;
                        normsum_n = '0;
                        round_n   = 1'b0;
                        sticky_n  = 1'b0;
                        overexp_n = '0;
                        state_n   = DONE;
                    end
                    c_norm: begin
                        normsum_n = w[WSIG:1];
                        round_n   = w[0];
                        sticky_n  = stk;
                        overexp_n = e[WEXP-1:0] - XONE;
                        state_n   = DONE;
                    end
                    c_min: begin
                        denorm_n  = 1'b1;
                        normsum_n = w[WSIG:1];
                        round_n   = w[0];
                        sticky_n  = stk;
                        overexp_n = '0;
                        state_n   = DONE;
                    end
                    default: begin
                        w_n = {w[WW-2:0], 1'b0};
                        e_n = e - EONE;
                    end
                endcase
            end

            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            w         <= '0;
            e         <= '0;
            stk       <= 1'b0;
            normsum   <= '0;
            round     <= 1'b0;
            sticky    <= 1'b0;
            overexp   <= '0;
            finalsign <= 1'b0;
            zero      <= 1'b0;
            denorm    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            w         <= w_n;
            e         <= e_n;
            stk       <= stk_n;
            normsum   <= normsum_n;
            round     <= round_n;
            sticky    <= sticky_n;
            overexp   <= overexp_n;
            finalsign <= finalsign_n;
            zero      <= zero_n;
            denorm    <= denorm_n;
            overflow  <= overflow_n;
        end
    end

endmodule

// File: tb/tb_iter_normalizer.sv
// tb_iter_normalizer: directed bench for iter_normalizer.
// Runs hand-computed vectors, backpressure and a mid-shift reset.
module tb_iter_normalizer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] rawsum;
    logic        stickyin;
    logic [7:0]  inexp;
    logic        signin;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] normsum;
    logic        round;
    logic        sticky;
    logic [7:0]  overexp;
    logic        finalsign;
    logic        zero;
    logic        denorm;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    iter_normalizer #(.WSIG(23), .WEXP(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rawsum    (rawsum),
        .stickyin  (stickyin),
        .inexp     (inexp),
        .signin    (signin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .normsum   (normsum),
        .round     (round),
        .sticky    (sticky),
        .overexp   (overexp),
        .finalsign (finalsign),
        .zero      (zero),
        .denorm    (denorm),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string       name,
                          input logic [25:0] raw,
                          input logic        stk,
                          input logic [7:0]  ex,
                          input logic        sg,
                          input int          lat,
                          input int          hold,
                          input logic [22:0] ens,
                          input logic        er,
                          input logic        es,
                          input logic [7:0]  eoe,
                          input logic        ez,
                          input logic        ed,
                          input logic        eo);
        int n;
        bit done;
        @(negedge clk);
        check({name, ".in_ready"}, 32'(in_ready), 32'd1);
        rawsum   = raw;
        stickyin = stk;
        inexp    = ex;
        signin   = sg;
        in_valid = 1'b1;
        out_ready = 1'b0;
        n = 0;
        done = 1'b0;
        while (!done && n < 60) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n++;
            if (out_valid) done = 1'b1;
        end
        check({name, ".lat"}, 32'(n), 32'(lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, ".hold_v"}, 32'(out_valid), 32'd1);
            check({name, ".hold_r"}, 32'(in_ready), 32'd0);
            check({name, ".hold_ns"}, 32'(normsum), 32'(ens));
            check({name, ".hold_oe"}, 32'(overexp), 32'(eoe));
        end
        check({name, ".normsum"}, 32'(normsum), 32'(ens));
        check({name, ".round"}, 32'(round), 32'(er));
        check({name, ".sticky"}, 32'(sticky), 32'(es));
        check({name, ".overexp"}, 32'(overexp), 32'(eoe));
        check({name, ".sign"}, 32'(finalsign), 32'(sg));
        check({name, ".zero"}, 32'(zero), 32'(ez));
        check({name, ".denorm"}, 32'(denorm), 32'(ed));
        check({name, ".ovf"}, 32'(overflow), 32'(eo));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, ".done_v"}, 32'(out_valid), 32'd0);
        check({name, ".done_r"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        rawsum    = '0;
        stickyin  = 1'b0;
        inexp     = '0;
        signin    = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.normsum", 32'(normsum), 32'd0);
        check("rst.overexp", 32'(overexp), 32'd0);
        check("rst.flags", 32'({zero, denorm, overflow}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        //     name     raw          stk ex    sg lat hold ns          r  s  oe   z  d  o
        run_op("carry", 26'h2000003, 0, 8'd127, 0, 2, 0, 23'h0,      1, 1, 127, 0, 0, 0);
        run_op("norm",  26'h1000001, 0, 8'd100, 1, 2, 0, 23'h0,      1, 0, 99,  0, 0, 0);
        run_op("canc",  26'h0000004, 0, 8'd127, 0, 24, 0, 23'h0,     0, 0, 104, 0, 0, 0);
        run_op("zero",  26'h0000000, 0, 8'd50,  1, 2, 0, 23'h0,      0, 0, 0,   1, 0, 0);
        run_op("ovf",   26'h2000000, 0, 8'd254, 0, 2, 0, 23'h0,      0, 0, 254, 0, 0, 1);
        run_op("exp0",  26'h0000004, 0, 8'd0,   0, 2, 0, 23'h2,      0, 0, 0,   0, 1, 0);
        run_op("stkonly", 26'h0,     1, 8'd2,   0, 3, 0, 23'h0,      0, 1, 0,   0, 1, 0);
        run_op("bp",    26'h1ABCDEF, 1, 8'd200, 1, 2, 5, 23'h55E6F7, 1, 1, 199, 0, 0, 0);
        run_op("sub",   26'h0000004, 0, 8'd3,   1, 4, 0, 23'h000008, 0, 0, 0,   0, 1, 0);

        // reset during a long cancellation shift
        @(negedge clk);
        rawsum   = 26'h0000004;
        stickyin = 1'b0;
        inexp    = 8'd127;
        signin   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("mid.in_ready", 32'(in_ready), 32'd0);
        check("mid.sign", 32'(finalsign), 32'd1);
        reset = 1'b1;
        #1;
        check("rstmid.out_valid", 32'(out_valid), 32'd0);
        check("rstmid.normsum", 32'(normsum), 32'd0);
        check("rstmid.sign", 32'(finalsign), 32'd0);
        check("rstmid.denorm", 32'(denorm), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid.in_ready", 32'(in_ready), 32'd1);

        run_op("post",  26'h2000003, 0, 8'd127, 0, 2, 0, 23'h0,      1, 1, 127, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_normalizer.md
Name: iter_normalizer

Overview:
Multi-cycle normalizer for the FP adder datapath. It sits between the significand adder and the rounder. It takes the raw adder sum with guard and sticky bits, then left-shifts it one bit per cycle until the hidden bit is set, or right-shifts it once on carry-out. It produces normsum, round, sticky and overexp in the convention the rounder expects: final exponent = overexp + 1, or + 2 on rounding overflow. Valid/ready handshakes sit on both sides.

Parameters:
WSIG, 23, stored fraction width, no hidden bit (matches `WSIG)
WEXP, 8, biased exponent width (matches `WEXP)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input transfer request
in_ready  output  1  block can accept input
rawsum  input  WSIG+3  adder sum: [WSIG+2] carry, [WSIG+1] hidden, [WSIG:1] fraction, [0] guard
stickyin  input  1  OR of alignment-shifted-out bits
inexp  input  WEXP  biased exponent of larger operand
signin  input  1  result sign
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
normsum  output  WSIG  normalized fraction, no hidden bit
round  output  1  round bit for rounder
sticky  output  1  sticky bit for rounder
overexp  output  WEXP  result exponent minus 1
finalsign  output  1  registered signin
zero  output  1  exact zero result
denorm  output  1  result subnormal (shifting stopped at min exponent)
overflow  output  1  carry pushed exponent to all-ones

Behaviour:
- FSM states: IDLE, SHIFT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Reset (async, any state): state=IDLE; all outputs and working registers 0; any in-flight operation is discarded.
- IDLE, on in_valid & in_ready:
  - capture working significand w = rawsum, stickyin, signin.
  - capture working exponent e (WEXP+1 bits) = max(inexp,1), so inexp=0 is treated as weight 1.
  - go to SHIFT.
- SHIFT evaluates once per cycle, first match wins:
  - carry, w[WSIG+2]=1:
    - normsum=w[WSIG+1:2], round=w[1], sticky=w[0]|stickyin.
    - overexp=e[WEXP-1:0].
    - overflow=(e==2^WEXP-2).
    - go to DONE.
  - w==0 and stickyin==0: zero=1, normsum=0, round=0, sticky=0, overexp=0; go to DONE.
  - w[WSIG+1]=1:
    - normsum=w[WSIG:1], round=w[0], sticky=stickyin.
    - overexp=e-1.
    - go to DONE.
  - e==1:
    - denorm=1, normsum=w[WSIG:1], round=w[0], sticky=stickyin, overexp=0.
    - go to DONE.
  - otherwise: w = w<<1 (LSB filled 0), e=e-1, stay in SHIFT.
- Flags zero, denorm and overflow are mutually exclusive and cleared on each new accept.
- Shift count is bounded by WSIG+2, because w becomes normalized or zero within that many shifts. No separate counter limit exists.
- Latency from accept edge to out_valid high: 2 cycles with no left shift; k+2 cycles with k left shifts.
- DONE: outputs are registered and held stable while out_valid & ~out_ready. On out_ready, go to IDLE; in_ready rises the next cycle.
- Throughput: at most one operation in flight. There is no accept while in SHIFT or DONE.
- in_valid while not in_ready is ignored; the source holds its data.

Test Plan:
- WSIG=23, WEXP=8. Carry: rawsum=26'h2000003, inexp=127, stickyin=0 -> normsum=0, round=1, sticky=1, overexp=127, overflow=0, out_valid 2 cycles after accept.
- Normalized: rawsum=26'h1000001, inexp=100 -> normsum=0, round=1, sticky=0, overexp=99, latency 2.
- Cancellation: rawsum=26'h0000004, inexp=127 -> 22 shifts, normsum=0, round=0, overexp=104, latency 24.
- Subnormal: rawsum=26'h0000004, inexp=3 -> 2 shifts, denorm=1, normsum=23'h000008, overexp=0.
- Zero and overflow:
  - rawsum=0, stickyin=0 -> zero=1, all data outputs 0, latency 2.
  - rawsum=26'h2000000, inexp=254 -> overflow=1, overexp=254.
- Backpressure and reset:
  - out_ready held 0 for 5 cycles -> outputs stable, in_ready=0.
  - Separately, assert reset mid-SHIFT -> all outputs 0 immediately, in_ready=1 after release, next operation correct.
